// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and loads the IF/ID register. It accepts jump redirects from the ID-stage
// decoder, holds on hazard stalls, and stops fetching on the undefined opcode 2'b10.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               id_jump,
    input  logic [PC_W-1:0]    id_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               halted
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            illegal;
    logic            redirect;

    // The memory read is combinational, so the fetched word is decoded in the same cycle.
    assign imem_addr = pc;
    assign illegal   = (imem_rdata[INSTR_W-1 -: 2] == 2'b10);
    // A jump only counts when ID holds a real instruction.
    assign redirect  = id_jump && ifid_valid;

    // Front-end FSM. This block also updates the PC and the IF/ID register.
    // In RUN the priority is: redirect, then stall, then illegal opcode, then normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    ifid_valid <= 1'b0;
                    ifid_instr <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // Squash the wrong-path fetch; an illegal word in IF dies with it.
                        pc         <= id_target;
                        ifid_valid <= 1'b0;
                        ifid_instr <= '0;
                    end else if (stall) begin
                        // Hold the PC and every IF/ID field.
                    end else if (illegal) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= '0;
                        halted     <= 1'b1;
                        state      <= HALT;
                    end else begin
                        ifid_instr <= imem_rdata;
                        ifid_pc    <= pc;
                        ifid_valid <= 1'b1;
                        pc         <= pc + 1'b1;
                    end
                end
                HALT: begin
                    ifid_valid <= 1'b0;
                    ifid_instr <= '0;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. It runs directed scenarios first, then randomized
// stall/jump/reset traffic. The reference model is kept as plain variables:
// PC, IF/ID contents, halt flag, and whether the next edge is the boot cycle.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       stall = 1'b0;
    logic       id_jump = 1'b0;
    logic [7:0] id_target = '0;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_pc;
    logic       ifid_valid;
    logic       halted;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0] m_pc, m_instr, m_ipc;
    logic       m_valid, m_halt, m_boot;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .id_jump(id_jump), .id_target(id_target),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_instr = 8'h00; m_ipc = 8'h00;
        m_valid = 1'b0; m_halt = 1'b0; m_boot = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   imem_addr,  m_pc);
        chk({tag, ".valid"},  ifid_valid, m_valid);
        chk({tag, ".instr"},  ifid_instr, m_instr);
        chk({tag, ".halted"}, halted,     m_halt);
        if (m_valid) chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
    endtask

    // One clock edge. The model applies the fetch rules to the inputs present before the edge.
    task automatic step(input string tag);
        logic [7:0] w;
        w = mem[m_pc];
        if (m_boot) m_boot = 1'b0;
        else if (m_halt) begin m_valid = 1'b0; m_instr = 8'h00; end
        else if (id_jump && m_valid) begin m_pc = id_target; m_valid = 1'b0; m_instr = 8'h00; end
        else if (stall) begin end
        else if (w[7:6] == 2'b10) begin m_halt = 1'b1; m_valid = 1'b0; m_instr = 8'h00; end
        else begin m_instr = w; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd1; end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle, check the async values, then release it before the next edge.
    task automatic pulse_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
        id_jump = 1'b0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h42; mem[2] = 8'h03; mem[3] = 8'hD0; mem[5] = 8'h80;
        model_reset();
        #2;
        check_all("reset");
        #6 reset = 1'b0;

        // Boot bubble, then words from PC 0, 1, 2, 3 on consecutive edges.
        step("boot");
        chk("boot.bubble", ifid_valid, 1'b0);
        step("f0"); chk("f0.pc", ifid_pc, 8'h00); chk("f0.w", ifid_instr, 8'h01);
        step("f1"); chk("f1.pc", ifid_pc, 8'h01); chk("f1.w", ifid_instr, 8'h42);
        step("f2"); chk("f2.pc", ifid_pc, 8'h02);
        step("f3"); chk("f3.w", ifid_instr, 8'hD0);

        // Jump from the instruction in ID: one bubble, then fetch resumes at the target.
        id_jump = 1'b1; id_target = 8'h10;
        step("jmp"); chk("jmp.addr", imem_addr, 8'h10);
        id_jump = 1'b0;
        step("jmp+1"); chk("jmp+1.pc", ifid_pc, 8'h10);
        step("run");

        // Three stalled edges freeze the front end.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall"); chk("stall.addr", imem_addr, 8'h12);
        end
        stall = 1'b0;
        step("resume"); chk("resume.pc", ifid_pc, 8'h12);
        // A jump wins over a stall on the same edge.
        stall = 1'b1; id_jump = 1'b1; id_target = 8'h20;
        step("stjmp"); chk("stjmp.addr", imem_addr, 8'h20);
        stall = 1'b0; id_jump = 1'b0;

        // Fetching 10_000000 at PC 5 halts the unit with the PC held at 5.
        pulse_reset("rst1");
        for (int i = 0; i < 18; i++) step("halt");
        chk("halt.flag", halted, 1'b1); chk("halt.pc", imem_addr, 8'h05);
        pulse_reset("rst_halt");

        // An illegal word in IF is discarded when a valid jump sits in ID.
        mem[0] = 8'hC5; mem[1] = 8'h80;
        step("ill.boot"); step("ill.f0");
        id_jump = 1'b1; id_target = 8'h30;
        step("ill.jmp"); chk("ill.halted", halted, 1'b0); chk("ill.addr", imem_addr, 8'h30);
        id_jump = 1'b0;
        step("ill.f");
        // Jump to 0xFF, then wrap the PC around to 0.
        id_jump = 1'b1; id_target = 8'hFF;
        step("wjmp");
        id_jump = 1'b0;
        step("wrap"); chk("wrap.pc", ifid_pc, 8'hFF); chk("wrap.addr", imem_addr, 8'h00);
        // Reset pulsed while a jump is being presented.
        id_jump = 1'b1; id_target = 8'h44;
        pulse_reset("rst_jmp");

        // Randomized traffic.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 31) == 0) ? 8'h80 | 8'($urandom_range(0, 63))
                                                   : 8'($urandom) & 8'hBF | 8'(($urandom_range(0, 1)) << 7) & 8'hC0 & ~8'h80 | (($urandom_range(0,1)) ? 8'hC0 & 8'hC0 : 8'h00);
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            id_jump   = ($urandom_range(0, 4) == 0);
            id_target = 8'($urandom);
            if (m_halt && $urandom_range(0, 7) == 0) pulse_reset("rnd.rst");
            else step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
